// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: control/datapath hand-off between the ALU stage and data memory,
// with valid, stall/flush and a registered branch-taken bit. Optional counters: EX_MEM_PERF_CNT_EN.
module ex_mem_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    input  logic                  in_mem_write,
    input  logic                  in_mem_read,
    input  logic                  in_branch,
    input  logic                  in_zflag,
    input  logic [DATA_W-1:0]     in_branch_target,
    input  logic [DATA_W-1:0]     in_alu_res,
    input  logic [DATA_W-1:0]     in_data2,
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    output logic                  out_valid,
    output logic                  out_reg_write,
    output logic                  out_mem_to_reg,
    output logic                  out_mem_write,
    output logic                  out_mem_read,
    output logic                  out_branch,
    output logic                  out_zflag,
    output logic                  out_pc_src,
    output logic [DATA_W-1:0]     out_branch_target,
    output logic [DATA_W-1:0]     out_alu_res,
    output logic [DATA_W-1:0]     out_data2,
    output logic [REG_ADDR_W-1:0] out_write_reg
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    localparam int CTRL_N = 6;

    logic [CTRL_N-1:0]     in_ctrl;
    logic [CTRL_N-1:0]     ctrl_reg;
    logic [CTRL_N-1:0]     ctrl_next;
    logic                  valid_reg;
    logic                  valid_next;
    logic                  pc_src_reg;
    logic                  pc_src_next;
    logic [DATA_W-1:0]     target_reg;
    logic [DATA_W-1:0]     target_next;
    logic [DATA_W-1:0]     alu_res_reg;
    logic [DATA_W-1:0]     alu_res_next;
    logic [DATA_W-1:0]     data2_reg;
    logic [DATA_W-1:0]     data2_next;
    logic [REG_ADDR_W-1:0] write_reg_reg;
    logic [REG_ADDR_W-1:0] write_reg_next;
    logic                  hold_data;

    assign in_ctrl = {in_zflag, in_branch, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write};

    // Control bits are cleared by a flush and gated by valid on load, so a bubble is inert.
    generate
        for (genvar gi = 0; gi < CTRL_N; gi++) begin : g_ctrl
            always_comb begin
                ctrl_next[gi] = in_ctrl[gi] & in_valid;
                if (flush) begin
                    ctrl_next[gi] = 1'b0;
                end else if (stall) begin
                    ctrl_next[gi] = ctrl_reg[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        valid_next  = in_valid;
        pc_src_next = in_valid & in_branch & in_zflag;
        if (flush) begin
            valid_next  = 1'b0;
            pc_src_next = 1'b0;
        end else if (stall) begin
            valid_next  = valid_reg;
            pc_src_next = pc_src_reg;
        end
    end

    // Datapath is never cleared by a flush; the cleared control makes its contents irrelevant.
    assign hold_data = flush | stall;

    always_comb begin
        target_next    = in_branch_target;
        alu_res_next   = in_alu_res;
        data2_next     = in_data2;
        write_reg_next = in_write_reg;
        if (hold_data) begin
            target_next    = target_reg;
            alu_res_next   = alu_res_reg;
            data2_next     = data2_reg;
            write_reg_next = write_reg_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_reg      <= '0;
            valid_reg     <= 1'b0;
            pc_src_reg    <= 1'b0;
            target_reg    <= '0;
            alu_res_reg   <= '0;
            data2_reg     <= '0;
            write_reg_reg <= '0;
        end else begin
            ctrl_reg      <= ctrl_next;
            valid_reg     <= valid_next;
            pc_src_reg    <= pc_src_next;
            target_reg    <= target_next;
            alu_res_reg   <= alu_res_next;
            data2_reg     <= data2_next;
            write_reg_reg <= write_reg_next;
        end
    end

    assign out_valid         = valid_reg;
    assign out_reg_write     = ctrl_reg[0];
    assign out_mem_to_reg    = ctrl_reg[1];
    assign out_mem_write     = ctrl_reg[2];
    assign out_mem_read      = ctrl_reg[3];
    assign out_branch        = ctrl_reg[4];
    assign out_zflag         = ctrl_reg[5];
    assign out_pc_src        = pc_src_reg;
    assign out_branch_target = target_reg;
    assign out_alu_res       = alu_res_reg;
    assign out_data2         = data2_reg;
    assign out_write_reg     = write_reg_reg;

`ifdef EX_MEM_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;
    logic [CNT_W-1:0] flush_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_next;

    // Saturating: a counter stuck at all-ones means "at least this many".
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if (stall && !flush && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
        if (flush && (flush_cnt_reg != {CNT_W{1'b1}})) begin
            flush_cnt_next = flush_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`else
    // CNT_W only sizes the optional counters; nothing to build without them.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: directed plan steps then random cycles against a per-edge rule model.
module tb_ex_mem_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush;
    logic        in_valid, in_reg_write, in_mem_to_reg, in_mem_write, in_mem_read, in_branch, in_zflag;
    logic [31:0] in_branch_target, in_alu_res, in_data2;
    logic [4:0]  in_write_reg;
    logic        out_valid, out_reg_write, out_mem_to_reg, out_mem_write, out_mem_read, out_branch, out_zflag;
    logic        out_pc_src;
    logic [31:0] out_branch_target, out_alu_res, out_data2;
    logic [4:0]  out_write_reg;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        valid, rw, m2r, mw, mr, br, z;
        logic [31:0] bt, alu, d2;
        logic [4:0]  wr;
    } in_t;

    typedef struct packed {
        logic        valid, rw, m2r, mw, mr, br, z, pc_src;
        logic [31:0] bt, alu, d2;
        logic [4:0]  wr;
    } exp_t;

    exp_t        m;
    in_t         s;
    longint      scnt_m, fcnt_m, scnt2_m, fcnt2_m;

    always #5 clk = ~clk;

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic [1:0]  stall_cnt2, flush_cnt2;
    logic        o2_valid, o2_rw, o2_m2r, o2_mw, o2_mr, o2_br, o2_z, o2_pc;
    logic [31:0] o2_bt, o2_alu, o2_d2;
    logic [4:0]  o2_wr;

    ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_mem_write(in_mem_write), .in_mem_read(in_mem_read), .in_branch(in_branch),
        .in_zflag(in_zflag), .in_branch_target(in_branch_target), .in_alu_res(in_alu_res),
        .in_data2(in_data2), .in_write_reg(in_write_reg),
        .out_valid(o2_valid), .out_reg_write(o2_rw), .out_mem_to_reg(o2_m2r),
        .out_mem_write(o2_mw), .out_mem_read(o2_mr), .out_branch(o2_br), .out_zflag(o2_z),
        .out_pc_src(o2_pc), .out_branch_target(o2_bt), .out_alu_res(o2_alu),
        .out_data2(o2_d2), .out_write_reg(o2_wr),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );
`endif

    ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_mem_write(in_mem_write), .in_mem_read(in_mem_read), .in_branch(in_branch),
        .in_zflag(in_zflag), .in_branch_target(in_branch_target), .in_alu_res(in_alu_res),
        .in_data2(in_data2), .in_write_reg(in_write_reg),
        .out_valid(out_valid), .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
        .out_mem_write(out_mem_write), .out_mem_read(out_mem_read), .out_branch(out_branch),
        .out_zflag(out_zflag), .out_pc_src(out_pc_src), .out_branch_target(out_branch_target),
        .out_alu_res(out_alu_res), .out_data2(out_data2), .out_write_reg(out_write_reg)
`ifdef EX_MEM_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  64'(out_valid),         64'(m.valid));
        chk({tag, ".rw"},     64'(out_reg_write),     64'(m.rw));
        chk({tag, ".m2r"},    64'(out_mem_to_reg),    64'(m.m2r));
        chk({tag, ".mw"},     64'(out_mem_write),     64'(m.mw));
        chk({tag, ".mr"},     64'(out_mem_read),      64'(m.mr));
        chk({tag, ".br"},     64'(out_branch),        64'(m.br));
        chk({tag, ".z"},      64'(out_zflag),         64'(m.z));
        chk({tag, ".pc_src"}, 64'(out_pc_src),        64'(m.pc_src));
        chk({tag, ".bt"},     64'(out_branch_target), 64'(m.bt));
        chk({tag, ".alu"},    64'(out_alu_res),       64'(m.alu));
        chk({tag, ".d2"},     64'(out_data2),         64'(m.d2));
        chk({tag, ".wr"},     64'(out_write_reg),     64'(m.wr));
`ifdef EX_MEM_PERF_CNT_EN
        chk({tag, ".scnt"},   64'(stall_cnt),         64'(scnt_m));
        chk({tag, ".fcnt"},   64'(flush_cnt),         64'(fcnt_m));
        chk({tag, ".scnt2"},  64'(stall_cnt2),        64'(scnt2_m));
        chk({tag, ".fcnt2"},  64'(flush_cnt2),        64'(fcnt2_m));
`endif
    endtask

    // Apply one edge of stimulus, advance the model by the pipeline rules, then compare.
    task automatic step(input string tag, input logic r, input logic st, input logic fl, input in_t i);
        rst_n = r; stall = st; flush = fl;
        in_valid = i.valid; in_reg_write = i.rw; in_mem_to_reg = i.m2r; in_mem_write = i.mw;
        in_mem_read = i.mr; in_branch = i.br; in_zflag = i.z;
        in_branch_target = i.bt; in_alu_res = i.alu; in_data2 = i.d2; in_write_reg = i.wr;
        @(posedge clk);
        if (!r) begin
            m = '0;
            scnt_m = 0; fcnt_m = 0; scnt2_m = 0; fcnt2_m = 0;
        end else begin
            if (fl) begin
                {m.valid, m.rw, m.m2r, m.mw, m.mr, m.br, m.z, m.pc_src} = '0;
                if (fcnt_m < 64'hFFFF_FFFF) fcnt_m++;
                if (fcnt2_m < 3) fcnt2_m++;
            end else if (st) begin
                if (scnt_m < 64'hFFFF_FFFF) scnt_m++;
                if (scnt2_m < 3) scnt2_m++;
            end else begin
                m.valid  = i.valid;
                m.rw     = i.valid & i.rw;
                m.m2r    = i.valid & i.m2r;
                m.mw     = i.valid & i.mw;
                m.mr     = i.valid & i.mr;
                m.br     = i.valid & i.br;
                m.z      = i.valid & i.z;
                m.pc_src = i.valid & i.br & i.z;
                m.bt = i.bt; m.alu = i.alu; m.d2 = i.d2; m.wr = i.wr;
            end
        end
        #1;
        check_all(tag);
        $display("step %-8s rst_n=%0d stall=%0d flush=%0d valid=%0d alu=%08h pc_src=%0d",
                 tag, r, st, fl, out_valid, out_alu_res, out_pc_src);
    endtask

    initial begin
        m = '0;
        scnt_m = 0; fcnt_m = 0; scnt2_m = 0; fcnt2_m = 0;

        // Reset with every input high.
        s = '1;
        step("rst0", 1'b0, 1'b1, 1'b1, s);
        chk("rst0.alu_zero", 64'(out_alu_res), 64'h0);
        step("rst1", 1'b0, 1'b1, 1'b1, s);
        chk("rst1.valid_zero", 64'(out_valid), 64'h0);

        // Load.
        s = '0; s.valid = 1; s.rw = 1; s.alu = 32'h0000_1234; s.wr = 5'd31;
        step("load", 1'b1, 1'b0, 1'b0, s);
        chk("load.alu_const", 64'(out_alu_res), 64'h1234);
        chk("load.wr_const",  64'(out_write_reg), 64'd31);

        // Branch taken / not taken.
        s = '0; s.valid = 1; s.br = 1; s.z = 1; s.bt = 32'h0040_0020;
        step("brtk", 1'b1, 1'b0, 1'b0, s);
        chk("brtk.pc_src_const", 64'(out_pc_src), 64'h1);
        s.z = 0;
        step("brnt", 1'b1, 1'b0, 1'b0, s);
        chk("brnt.pc_src_const", 64'(out_pc_src), 64'h0);

        // Invalid branch must not redirect.
        s = '1; s.valid = 0;
        step("bubble", 1'b1, 1'b0, 1'b0, s);

        // Stall holds for three edges, release loads the waiting value.
        s = '0; s.valid = 1; s.alu = 32'hAAAA_0001;
        step("pre_st", 1'b1, 1'b0, 1'b0, s);
        s.alu = 32'h0000_5555;
        for (int k = 0; k < 3; k++) step("stall", 1'b1, 1'b1, 1'b0, s);
        chk("stall.alu_const", 64'(out_alu_res), 64'hAAAA_0001);
        step("release", 1'b1, 1'b0, 1'b0, s);
        chk("release.alu_const", 64'(out_alu_res), 64'h5555);

        // Flush beats simultaneous stall; datapath holds.
        s = '0; s.valid = 1; s.mw = 1; s.br = 1; s.z = 1; s.alu = 32'hCAFE_0004;
        step("pre_fl", 1'b1, 1'b0, 1'b0, s);
        s.alu = 32'h1111_1111;
        step("flst", 1'b1, 1'b1, 1'b1, s);
        chk("flst.alu_const", 64'(out_alu_res), 64'hCAFE_0004);
        chk("flst.mw_const",  64'(out_mem_write), 64'h0);

        // Reset released while stalled: held value is the reset value.
        s = '1;
        step("rst2", 1'b0, 1'b0, 1'b0, s);
        step("st_rst", 1'b1, 1'b1, 1'b0, s);
        chk("st_rst.alu_const", 64'(out_alu_res), 64'h0);

`ifdef EX_MEM_PERF_CNT_EN
        // 4 stall edges (one also flushing) and 2 flush edges in total.
        s = '0;
        step("crst", 1'b0, 1'b0, 1'b0, s);
        step("c_s", 1'b1, 1'b1, 1'b0, s);
        step("c_s", 1'b1, 1'b1, 1'b0, s);
        step("c_s", 1'b1, 1'b1, 1'b0, s);
        step("c_sf", 1'b1, 1'b1, 1'b1, s);
        step("c_f", 1'b1, 1'b0, 1'b1, s);
        chk("cnt.stall_const", 64'(stall_cnt), 64'd3);
        chk("cnt.flush_const", 64'(flush_cnt), 64'd2);
        for (int k = 0; k < 5; k++) step("c_sat", 1'b1, 1'b1, 1'b0, s);
        chk("cnt.sat_const", 64'(stall_cnt2), 64'd3);
`endif

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            logic r, st, fl;
            s.valid = 1'($urandom); s.rw = 1'($urandom); s.m2r = 1'($urandom);
            s.mw = 1'($urandom); s.mr = 1'($urandom); s.br = 1'($urandom); s.z = 1'($urandom);
            s.bt = $urandom; s.alu = $urandom; s.d2 = $urandom; s.wr = 5'($urandom);
            r  = ($urandom_range(0, 39) != 0);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            step("rand", r, st, fl, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
